count_event_monitor: RTL

- Downstream consumer of the up-counter's count output; sits beside the counter and watches count and enable every cycle.
- Checks that the count advances correctly and detects wrap-around and a programmable threshold crossing.
- Queues event records in a small FIFO with a valid/ready output and raises a sticky interrupt.

---
 rtl/count_event_monitor_pkg.sv | 27 ++
 rtl/count_event_monitor_sync_fifo.sv | 65 ++++++
 rtl/count_event_monitor.sv | 115 +++++++++++
 3 files changed

// File: rtl/count_event_monitor_pkg.sv
// Shared definitions for the count event monitor: flag bit positions,
// the event record layout and the expected-next-count helper.
// No ports; imported by count_event_monitor and its bench.
package cnt_mon_pkg;

  // Bit positions inside the 3-bit flag field of an event record.
  localparam int FLG_THRESH = 0;
  localparam int FLG_WRAP   = 1;
  localparam int FLG_ERR    = 2;
  localparam int NFLAGS     = 3;

  // Default counter width used by the record typedef.
  localparam int CW_DEF     = 4;

  typedef struct packed {
    logic [NFLAGS-1:0] flags;
    logic [CW_DEF-1:0] cnt;
  } evt_rec_t;

  // Value the counter should hold one cycle after 'prev' given its enable.
  // Computed at 32 bits; callers truncate to their width, which gives
  // the modulo-2^CW wrap for free.
  function automatic logic [31:0] next_count(input logic [31:0] prev, input logic en);
    return en ? prev + 32'd1 : prev;
  endfunction

endpackage

// File: rtl/count_event_monitor_sync_fifo.sv
// Synchronous FIFO holding event records.
// Ports: clk, rst_n (async active-low), push/push_dat, pop/pop_dat,
// full, empty. Push while full is accepted when a pop happens the same cycle.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign pop_dat = mem_q[rd_ptr_q];

  // Pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the read side is only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/count_event_monitor.sv
// Watches an up-counter's count/enable, flags ERR/WRAP/THRESH events and
// queues {flags, count} records in a FIFO with valid/ready output.
// Ports: clk, reset (async active-low), ctr_reset, enable, count, thresh,
// clr_irq, evt_ready -> evt_valid, evt_data, irq, ovf, wrap_cnt.
module count_event_monitor
  import cnt_mon_pkg::*;
#(
  parameter int CW    = 4,
  parameter int DEPTH = 4,
  parameter int WW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ctr_reset,
  input  logic          enable,
  input  logic [CW-1:0] count,
  input  logic [CW-1:0] thresh,
  input  logic          clr_irq,
  input  logic          evt_ready,
  output logic          evt_valid,
  output logic [CW+2:0] evt_data,
  output logic          irq,
  output logic          ovf,
  output logic [WW-1:0] wrap_cnt
);

  logic [CW-1:0]     prev_count_q, prev_count_d;
  logic              prev_en_q, prev_en_d;
  logic              armed_q, armed_d;
  logic              irq_q, irq_d;
  logic              ovf_q, ovf_d;
  logic [WW-1:0]     wrap_cnt_q, wrap_cnt_d;

  logic              check_en;
  logic [CW-1:0]     exp_count;
  logic [NFLAGS-1:0] flags;
  logic              push, pop_fire, drop;
  logic              fifo_full, fifo_empty;
  logic [CW+2:0]     fifo_dat;

  // A cycle with ctr_reset high (or the first cycle out of reset) leaves
  // prev_count unrelated to the next count, so the next cycle is skipped.
  assign check_en  = armed_q && !ctr_reset;
  assign exp_count = CW'(next_count(32'(prev_count_q), prev_en_q));

  always_comb begin
    flags             = '0;
    flags[FLG_ERR]    = check_en && (count != exp_count);
    flags[FLG_WRAP]   = check_en && prev_en_q && (prev_count_q == '1) && (count == '0);
    // Only the first cycle at the threshold fires; holding there is quiet.
    flags[FLG_THRESH] = check_en && (count == thresh) && (count != prev_count_q);
  end

  assign push     = |flags;
  assign pop_fire = evt_ready && !fifo_empty;
  assign drop     = push && fifo_full && !pop_fire;

  always_comb begin
    prev_count_d = count;
    prev_en_d    = enable;
    armed_d      = !ctr_reset;

    // Set wins over a simultaneous clear.
    irq_d = irq_q;
    if (clr_irq) irq_d = 1'b0;
    if (push)    irq_d = 1'b1;

    ovf_d = ovf_q;
    if (clr_irq) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;

    wrap_cnt_d = wrap_cnt_q;
    if (flags[FLG_WRAP] && (wrap_cnt_q != '1)) wrap_cnt_d = wrap_cnt_q + WW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_count_q <= '0;
      prev_en_q    <= 1'b0;
      armed_q      <= 1'b0;
      irq_q        <= 1'b0;
      ovf_q        <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      prev_count_q <= prev_count_d;
      prev_en_q    <= prev_en_d;
      armed_q      <= armed_d;
      irq_q        <= irq_d;
      ovf_q        <= ovf_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  sync_fifo #(
    .W     (CW + 3),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_dat ({flags, count}),
    .pop      (evt_ready),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Data reads as zero while nothing is queued (including during reset).
  assign evt_valid = !fifo_empty;
  assign evt_data  = fifo_empty ? '0 : fifo_dat;
  assign irq       = irq_q;
  assign ovf       = ovf_q;
  assign wrap_cnt  = wrap_cnt_q;

endmodule
